// File: rtl/wide_add_sequencer.sv
// Wide add/subtract sequencer built around one shared 32-bit carry-bypass adder.
// Operands are processed one 32-bit slice per cycle, least significant slice
// first, with the carry chained between slices through a carry register.
// WORDS sets the number of slices and must be in the range 2..16.

// 32-bit carry-bypass adder, purely combinational; 8 blocks of 4 bits each.
module carry_bypass_adder (
    input  logic        clk,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout,
    output logic        overflow
);
    localparam int BLK_W  = 4;
    localparam int BLK_N  = 8;

    // clk is wired through for a uniform adder interface; the datapath is combinational
    logic        unused_clk_s;
    logic [31:0] sum_s;
    logic        chain_s;
    logic        blk_cin_s;
    logic        ripple_s;
    logic        prop_s;
    logic        bit_p_s;

    assign unused_clk_s = clk;

    // ripple inside each block; a fully propagating block passes its carry-in straight through
    always_comb begin
        sum_s     = 32'd0;
        chain_s   = cin;
        blk_cin_s = 1'b0;
        ripple_s  = 1'b0;
        prop_s    = 1'b0;
        bit_p_s   = 1'b0;
        for (int blk = 0; blk < BLK_N; blk++) begin
            blk_cin_s = chain_s;
            ripple_s  = chain_s;
            prop_s    = 1'b1;
            for (int i = 0; i < BLK_W; i++) begin
                bit_p_s                = a[blk*BLK_W + i] ^ b[blk*BLK_W + i];
                sum_s[blk*BLK_W + i]   = bit_p_s ^ ripple_s;
                ripple_s               = (a[blk*BLK_W + i] & b[blk*BLK_W + i]) | (bit_p_s & ripple_s);
                prop_s                 = prop_s & bit_p_s;
            end
            if (prop_s) begin
                chain_s = blk_cin_s;
            end else begin
                chain_s = ripple_s;
            end
        end
    end

    assign sum      = sum_s;
    assign cout     = chain_s;
    // signed overflow: operands agree in sign but the result does not
    assign overflow = (a[31] ~^ b[31]) & (sum_s[31] ^ a[31]);

endmodule

module wide_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [32*WORDS-1:0]   in_a,
    input  logic [32*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_overflow,
    output logic                  busy
);
    localparam int              SLICE_W  = 32;
    localparam int              OP_W     = SLICE_W * WORDS;
    localparam int              CNT_W    = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                carry_r;
    logic [OP_W-1:0]     a_r;
    logic [OP_W-1:0]     b_r;
    logic [OP_W-1:0]     out_sum_r;
    logic                out_cout_r;
    logic                out_ovf_r;
    logic                out_valid_r;
    logic                busy_r;
    logic                in_ready_r;

    logic [31:0]         add_a_s;
    logic [31:0]         add_b_s;
    logic [31:0]         add_sum_s;
    logic                add_cout_s;
    logic                add_ovf_s;

    // current slice of the latched operands feeds the shared adder
    assign add_a_s = a_r[SLICE_W*cnt_r +: SLICE_W];
    assign add_b_s = b_r[SLICE_W*cnt_r +: SLICE_W];

    carry_bypass_adder u_adder (
        .clk      (clk),
        .a        (add_a_s),
        .b        (add_b_s),
        .cin      (carry_r),
        .sum      (add_sum_s),
        .cout     (add_cout_s),
        .overflow (add_ovf_s)
    );

    // sequencer FSM: accept operands, walk the slices, hold the result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            carry_r     <= 1'b0;
            a_r         <= {OP_W{1'b0}};
            b_r         <= {OP_W{1'b0}};
            out_sum_r   <= {OP_W{1'b0}};
            out_cout_r  <= 1'b0;
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= in_a;
                        // subtraction is A + ~B + 1, so B is inverted once here
                        b_r        <= in_sub ? ~in_b : in_b;
                        carry_r    <= in_sub ? 1'b1 : in_cin;
                        cnt_r      <= {CNT_W{1'b0}};
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    out_sum_r[SLICE_W*cnt_r +: SLICE_W] <= add_sum_s;
                    carry_r                             <= add_cout_s;
                    if (cnt_r == LAST_CNT) begin
                        out_cout_r  <= add_cout_s;
                        out_ovf_r   <= add_ovf_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= {CNT_W{1'b0}};
                    carry_r     <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    // in_ready drops immediately while reset is held
    assign in_ready     = in_ready_r & ~rst;
    assign out_valid    = out_valid_r;
    assign out_sum      = out_sum_r;
    assign out_cout     = out_cout_r;
    assign out_overflow = out_ovf_r;
    assign busy         = busy_r;

endmodule
